// File: rtl/mux_rr_n.sv
// rtl/mux_rr_n.sv - N-channel registered mux with manual or round-robin channel selection
// Valid/ready on every input and on the output; the single output register may refill while it drains.
module mux_rr_n #(
   parameter int N     = 8,
   parameter int W     = 1,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_mode,
   input  logic [SEL_W-1:0] i_sel,
   input  logic [N*W-1:0]   i_in_data,
   input  logic [N-1:0]     i_in_valid,
   output logic [N-1:0]     o_in_ready,
   output logic [W-1:0]     o_out_data,
   output logic [SEL_W-1:0] o_out_sel,
   output logic             o_out_valid,
   input  logic             i_out_ready
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           r_state;
   logic [W-1:0]     r_data;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] r_ptr;

   logic             w_load_en;
   logic             w_found;
   logic [SEL_W-1:0] w_grant;
   logic [W-1:0]     w_grant_data;

   assign w_load_en = (r_state == EMPTY) || i_out_ready;

   // Round-robin scans ptr..N-1 then 0..ptr-1; the index wraps at N, not at 2**SEL_W.
   always_comb begin
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_grant = '0;
      if (i_mode) begin
         for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_found && i_in_valid[idx]) begin
               w_found = 1'b1;
               w_grant = SEL_W'(idx);
            end
         end
      end else if (int'(i_sel) < N) begin
         if (i_in_valid[i_sel]) begin
            w_found = 1'b1;
            w_grant = i_sel;
         end
      end
   end

   assign w_grant_data = i_in_data[int'(w_grant)*W +: W];
   assign o_in_ready   = (w_load_en && w_found && !rst)
                         ? ({{(N-1){1'b0}}, 1'b1} << w_grant) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
         r_data  <= '0;
         r_sel   <= '0;
         r_ptr   <= '0;
      end else if (w_load_en) begin
         if (w_found) begin
            r_state <= FULL;
            r_data  <= w_grant_data;
            r_sel   <= w_grant;
            if (i_mode)
               r_ptr <= (int'(w_grant) == N-1) ? '0 : w_grant + 1'b1;
         end else begin
            r_state <= EMPTY;
         end
      end
   end

   assign o_out_valid = (r_state == FULL);
   assign o_out_data  = r_data;
   assign o_out_sel   = r_sel;

endmodule

// File: tb/tb_mux_rr_n.sv
// tb/tb_mux_rr_n.sv - table-driven bench for mux_rr_n with an output scoreboard
// Each vector carries hand-derived in_ready and out_valid; granted words are queued and popped after the edge.
module tb_mux_rr_n;

   localparam int N     = 8;
   localparam int W     = 1;
   localparam int SEL_W = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             mode;
   logic [SEL_W-1:0] sel;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic [W-1:0]     out_data;
   logic [SEL_W-1:0] out_sel;
   logic             out_valid;
   logic             out_ready;

   mux_rr_n #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_mode      (mode),
      .i_sel       (sel),
      .i_in_data   (in_data),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .o_out_data  (out_data),
      .o_out_sel   (out_sel),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             mode;
      logic [SEL_W-1:0] sel;
      logic [N-1:0]     valid;
      logic [N-1:0]     data;
      logic             oready;
      logic [N-1:0]     exp_ready;
      logic             exp_valid;
   } vec_t;

   typedef struct {
      logic [W-1:0]     data;
      logic [SEL_W-1:0] sel;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [W-1:0]     last_data = '0;
   logic [SEL_W-1:0] last_sel  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic m, input logic [SEL_W-1:0] s, input logic [N-1:0] v,
                               input logic [N-1:0] d, input logic ordy,
                               input logic [N-1:0] er, input logic ev);
      vec_t x;
      x.mode = m; x.sel = s; x.valid = v; x.data = d; x.oready = ordy;
      x.exp_ready = er; x.exp_valid = ev;
      vecs.push_back(x);
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic apply(input vec_t v, input int idx);
      exp_t e;
      bit   pushed;
      mode = v.mode; sel = v.sel; in_valid = v.valid; in_data = v.data; out_ready = v.oready;
      #1;
      chk($sformatf("in_ready[%0d]", idx), 32'(in_ready), 32'(v.exp_ready));
      pushed = 0;
      for (int g = 0; g < N; g++) begin
         if (v.exp_ready[g]) begin
            e.data = v.data[g];
            e.sel  = SEL_W'(g);
            sb.push_back(e);
            pushed = 1;
         end
      end
      @(posedge clk);
      #1;
      chk($sformatf("out_valid[%0d]", idx), 32'(out_valid), 32'(v.exp_valid));
      if (pushed) begin
         if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty[%0d]: got 0 entries expected 1", idx);
         end else begin
            e = sb.pop_front();
            last_data = e.data;
            last_sel  = e.sel;
         end
      end
      chk($sformatf("out_data[%0d]", idx), 32'(out_data), 32'(last_data));
      chk($sformatf("out_sel[%0d]", idx), 32'(out_sel), 32'(last_sel));
      @(negedge clk);
   endtask

   initial begin
      mode = 1'b1; sel = '0; in_valid = 8'hFF; in_data = 8'hFF; out_ready = 1'b1;
      #2;
      chk("reset_in_ready", 32'(in_ready), 32'h0);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_out_data", 32'(out_data), 32'h0);
      chk("reset_out_sel", 32'(out_sel), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Manual sweep: out_data follows 0,1,0,1,1,0,1,0.
      for (int s = 0; s < N; s++)
         add(1'b0, SEL_W'(s), 8'hFF, 8'b0101_1010, 1'b1, 8'(1) << s, 1'b1);
      // Round-robin fairness, two full rotations from ptr=0.
      for (int k = 0; k < 2*N; k++)
         add(1'b1, 3'd0, 8'hFF, 8'b1100_1010, 1'b1, 8'(1) << (k % N), 1'b1);
      // Sparse requests with wrap: 1,7,1,7 then ptr=7 cases.
      for (int k = 0; k < 4; k++)
         add(1'b1, 3'd0, 8'b1000_0010, 8'b1000_0001, 1'b1, (k % 2 == 0) ? 8'b0000_0010 : 8'b1000_0000, 1'b1);
      add(1'b1, 3'd0, 8'b0100_0000, 8'b1000_0001, 1'b1, 8'b0100_0000, 1'b1);
      add(1'b1, 3'd0, 8'b1000_0001, 8'b1000_0001, 1'b1, 8'b1000_0000, 1'b1);
      add(1'b1, 3'd0, 8'b0100_0000, 8'b1000_0001, 1'b1, 8'b0100_0000, 1'b1);
      add(1'b1, 3'd0, 8'b0000_0001, 8'b1000_0001, 1'b1, 8'b0000_0001, 1'b1);
      // Backpressure: 5 stalled cycles, one accepting cycle, then stall again (ptr=1).
      for (int k = 0; k < 5; k++)
         add(1'b1, 3'd0, 8'hFF, 8'b0000_0010, 1'b0, 8'h00, 1'b1);
      add(1'b1, 3'd0, 8'hFF, 8'b0000_0010, 1'b1, 8'b0000_0010, 1'b1);
      add(1'b1, 3'd0, 8'hFF, 8'b0000_0000, 1'b0, 8'h00, 1'b1);
      add(1'b1, 3'd0, 8'hFF, 8'b0000_0000, 1'b0, 8'h00, 1'b1);
      // Manual miss on channel 5: pending word drains, then stays empty.
      add(1'b0, 3'd5, 8'b1101_1111, 8'h00, 1'b1, 8'h00, 1'b0);
      add(1'b0, 3'd5, 8'b1101_1111, 8'h00, 1'b1, 8'h00, 1'b0);
      // Mode switch while full: held word untouched, next grant uses ptr=2.
      add(1'b0, 3'd3, 8'hFF, 8'b0000_1000, 1'b1, 8'b0000_1000, 1'b1);
      add(1'b1, 3'd3, 8'hFF, 8'b0000_0000, 1'b0, 8'h00, 1'b1);
      add(1'b1, 3'd3, 8'hFF, 8'b0000_0100, 1'b1, 8'b0000_0100, 1'b1);
      // Drain to empty, then load while empty even with out_ready low.
      add(1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
      add(1'b1, 3'd0, 8'b0000_1000, 8'b0000_1000, 1'b0, 8'b0000_1000, 1'b1);

      foreach (vecs[i]) apply(vecs[i], i);

      // Asynchronous reset while holding channel 3 with data 1.
      mode = 1'b1; in_valid = 8'hFF; in_data = 8'hFF; out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'h0);
      chk("async_rst_out_data", 32'(out_data), 32'h0);
      chk("async_rst_out_sel", 32'(out_sel), 32'h0);
      chk("async_rst_in_ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      last_data = '0;
      last_sel  = '0;
      begin
         vec_t x;
         x.mode = 1'b1; x.sel = '0; x.valid = 8'hFF; x.data = 8'h01; x.oready = 1'b1;
         x.exp_ready = 8'b0000_0001; x.exp_valid = 1'b1;
         apply(x, 1000);
         x.exp_ready = 8'b0000_0010;
         apply(x, 1001);
      end

      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
